pa_iu_ag_arb: RTL and testbench
===============================

Name: pa_iu_ag_arb

Overview:
- Arbiter and sequencer for the shared EX1 address-generation adder.
- Two requesters compete for the adder: BJU (branch/jump/auipc target, optionally PC-based) and LSU (base-register writeback).
- The block grants one requester per cycle, drives the adder operand/select controls, captures the adder result into per-requester result registers, and prevents LSU starvation.
- Sits between IDU/LSU issue logic and the address generator in the IU.

Parameters:
STARVE_MAX, 3, consecutive LSU-denied cycles after which LSU receives forced priority (1..7).
CNT_W, 3, width of the LSU starvation counter.

Ports:
cpuclk  input  1  core clock
cpurst  input  1  asynchronous active-high reset
ifu_iu_flush  input  1  pipeline flush; kills BJU traffic
bju_ag_req_vld  input  1  BJU request valid
bju_ag_req_use_pc  input  1  BJU rs1 is the current PC
bju_ag_req_src0  input  32  BJU rs1 value
bju_ag_req_imm  input  32  BJU immediate
bju_ag_req_pc  input  32  BJU current PC
bju_ag_req_rdy  output  1  BJU granted this cycle
lsu_ag_req_vld  input  1  LSU base-writeback request valid
lsu_ag_req_base  input  32  LSU base register value
lsu_ag_req_offset  input  32  LSU offset
lsu_ag_req_rdy  output  1  LSU granted this cycle
ag_adder_rs1  output  32  adder operand 1 (PC bit0 forced 0 when PC used)
ag_adder_rs2  output  32  adder operand 2
ag_adder_bju_sel  output  1  adder working for BJU
ag_adder_lsu_wb  output  1  adder working for LSU
ag_adder_res  input  32  combinational adder sum for current operands
ag_bju_rslt_vld  output  1  BJU result valid, one-cycle pulse
ag_bju_rslt  output  32  BJU target, bit0 forced 0
ag_lsu_rslt_vld  output  1  LSU result valid, held until accepted
ag_lsu_rslt  output  32  updated base value
lsu_ag_rslt_rdy  input  1  LSU consumes result

Behaviour:
- Reset (asynchronous, cpurst=1): all valids 0, results 32'h0, starvation counter 0, FSM in IDLE. Outputs are stable from reset assertion.
- Grant is combinational in the request cycle; at most one grant per cycle.
  - lsu_eligible = lsu_ag_req_vld & ~lsu_hold (the output buffer is free or is draining this cycle).
  - LSU wins when lsu_eligible & (~bju_ag_req_vld | starve_cnt >= STARVE_MAX).
  - Otherwise BJU wins if bju_ag_req_vld & ~ifu_iu_flush.
- Operands:
  - Granted BJU: rs1 = use_pc ? {pc[31:1],1'b0} : src0; rs2 = imm.
  - Granted LSU: rs1 = base; rs2 = offset.
  - No grant: both operands 0, both sel signals 0.
- Latency: the result register is written at the clock edge ending the grant cycle, so results are visible 1 cycle after grant.
- BJU result: ag_bju_rslt = {res[31:1],1'b0}; vld pulses for exactly 1 cycle. If flush is asserted in the capture cycle, vld is suppressed. If flush is asserted while the result is valid, vld is not cleared (it is a pulse already consumed).
- LSU result buffer (1 entry), FSM:
  - L_IDLE -> L_FULL on LSU grant.
  - L_FULL -> L_IDLE when lsu_ag_rslt_rdy=1 and there is no new LSU grant.
  - L_FULL -> L_FULL with new data on rdy & grant (back-to-back).
  - L_FULL stays when rdy=0; lsu_hold=1 in this case and LSU is not granted.
  - Flush does not affect the LSU buffer (architecturally older instruction).
- Starvation counter:
  - Increments (saturating at 2^CNT_W-1) each cycle lsu_eligible=1 and LSU not granted.
  - Clears on LSU grant, on ~lsu_ag_req_vld, and on flush.
- Simultaneous events:
  - flush with a BJU-only request: no grant, rdy=0.
  - flush with both requests: LSU granted if eligible.
- Reset mid-operation: pending results are discarded; no vld after deassertion until a new grant.

Decomposition:
- Shared package pa_iu_ag_pkg holds: LSU FSM state encodings (L_IDLE=1'b0, L_FULL=1'b1), default STARVE_MAX, CNT_W, and the data width 32.
- One sub-module, pa_iu_ag_arb_starve_cnt: saturating counter with inc/clr inputs and a threshold compare output.
- Grant logic, operand mux and result registers stay in the top module.

Test Plan:
- BJU only, src0=32'h1000, imm=32'h20, use_pc=0 -> rdy=1 same cycle; next cycle ag_bju_rslt_vld=1, rslt=32'h1020, for 1 cycle only.
- BJU use_pc=1, pc=32'h8000_0003, imm=4 -> rs1=32'h8000_0002; rslt=32'h8000_0006.
- Both requesting continuously, STARVE_MAX=3 -> BJU granted 3 cycles, LSU granted on the 4th, counter cleared, pattern repeats.
- LSU granted (base=32'h100, off=8), lsu_ag_rslt_rdy=0 for 4 cycles -> rslt_vld held with 32'h108; lsu_ag_req_rdy=0 while held; counter stays 0 (not eligible); rdy=1 -> buffer drains, next LSU request grantable the same cycle.
- flush in the BJU grant cycle -> bju_ag_req_rdy=0, no ag_bju_rslt_vld; flush with an LSU request pending -> LSU granted, result delivered normally.
- Assert cpurst while ag_lsu_rslt_vld=1 -> vld=0 and rslt=0 immediately (asynchronous); after release, no vld without a new request.

Source files
------------

// File: rtl/pa_iu_ag_pkg.sv
// pa_iu_ag_pkg: shared widths, defaults and LSU result buffer states for the EX1 AG arbiter
package pa_iu_ag_pkg;
  localparam int DW = 32;
  localparam int STARVE_MAX_DEF = 3;
  localparam int CNT_W_DEF = 3;
  typedef enum logic {L_IDLE = 1'b0, L_FULL = 1'b1} lsu_st_e;
endpackage

// File: rtl/pa_iu_ag_arb_starve_cnt.sv
// pa_iu_ag_arb_starve_cnt: saturating LSU-denied counter with threshold flag
module pa_iu_ag_arb_starve_cnt #(
  parameter int CNT_W = 3,
  parameter int STARVE_MAX = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_hit
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_cnt <= '0;
    else r_cnt <= i_clr ? '0 : (i_inc && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
  assign o_hit = r_cnt >= CNT_W'(STARVE_MAX);
endmodule

// File: rtl/pa_iu_ag_arb.sv
// pa_iu_ag_arb: arbitrates the shared EX1 adder between BJU and LSU, captures results,
// and forces LSU priority after STARVE_MAX consecutive denials.
module pa_iu_ag_arb import pa_iu_ag_pkg::*; #(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic          cpuclk,
  input  logic          cpurst,
  input  logic          ifu_iu_flush,
  input  logic          bju_ag_req_vld,
  input  logic          bju_ag_req_use_pc,
  input  logic [DW-1:0] bju_ag_req_src0,
  input  logic [DW-1:0] bju_ag_req_imm,
  input  logic [DW-1:0] bju_ag_req_pc,
  output logic          bju_ag_req_rdy,
  input  logic          lsu_ag_req_vld,
  input  logic [DW-1:0] lsu_ag_req_base,
  input  logic [DW-1:0] lsu_ag_req_offset,
  output logic          lsu_ag_req_rdy,
  output logic [DW-1:0] ag_adder_rs1,
  output logic [DW-1:0] ag_adder_rs2,
  output logic          ag_adder_bju_sel,
  output logic          ag_adder_lsu_wb,
  input  logic [DW-1:0] ag_adder_res,
  output logic          ag_bju_rslt_vld,
  output logic [DW-1:0] ag_bju_rslt,
  output logic          ag_lsu_rslt_vld,
  output logic [DW-1:0] ag_lsu_rslt,
  input  logic          lsu_ag_rslt_rdy
);
  lsu_st_e       r_lsu_st;
  logic          r_bju_vld;
  logic [DW-1:0] r_bju_rslt, r_lsu_rslt;
  logic          w_bju_req, w_lsu_hold, w_lsu_elig, w_lsu_gnt, w_bju_gnt, w_starve;
  // a flushed BJU request no longer competes, so a pending LSU request takes the adder
  assign w_bju_req  = bju_ag_req_vld & ~ifu_iu_flush;
  assign w_lsu_hold = (r_lsu_st == L_FULL) & ~lsu_ag_rslt_rdy;
  assign w_lsu_elig = lsu_ag_req_vld & ~w_lsu_hold;
  assign w_lsu_gnt  = w_lsu_elig & (~w_bju_req | w_starve);
  assign w_bju_gnt  = w_bju_req & ~w_lsu_gnt;
  pa_iu_ag_arb_starve_cnt #(.CNT_W(CNT_W), .STARVE_MAX(STARVE_MAX)) u_starve (
    .i_clk(cpuclk),
    .i_rst(cpurst),
    .i_inc(w_lsu_elig & ~w_lsu_gnt),
    .i_clr(w_lsu_gnt | ~lsu_ag_req_vld | ifu_iu_flush),
    .o_hit(w_starve)
  );
  assign bju_ag_req_rdy   = w_bju_gnt;
  assign lsu_ag_req_rdy   = w_lsu_gnt;
  assign ag_adder_bju_sel = w_bju_gnt;
  assign ag_adder_lsu_wb  = w_lsu_gnt;
  assign ag_adder_rs1 = w_lsu_gnt ? lsu_ag_req_base :
                        w_bju_gnt ? (bju_ag_req_use_pc ? bju_ag_req_pc & ~DW'(1) : bju_ag_req_src0) : '0;
  assign ag_adder_rs2 = w_lsu_gnt ? lsu_ag_req_offset : w_bju_gnt ? bju_ag_req_imm : '0;
  always_ff @(posedge cpuclk or posedge cpurst)
    if (cpurst) begin
      r_bju_vld  <= 1'b0;
      r_bju_rslt <= '0;
    end else begin
      r_bju_vld <= w_bju_gnt;
      if (w_bju_gnt) r_bju_rslt <= ag_adder_res & ~DW'(1);
    end
  // single-entry LSU buffer; a draining entry may be replaced in the same cycle
  always_ff @(posedge cpuclk or posedge cpurst)
    if (cpurst) begin
      r_lsu_st   <= L_IDLE;
      r_lsu_rslt <= '0;
    end else if (w_lsu_gnt) begin
      r_lsu_st   <= L_FULL;
      r_lsu_rslt <= ag_adder_res;
    end else if (lsu_ag_rslt_rdy) r_lsu_st <= L_IDLE;
  assign ag_bju_rslt_vld = r_bju_vld;
  assign ag_bju_rslt     = r_bju_rslt;
  assign ag_lsu_rslt_vld = r_lsu_st == L_FULL;
  assign ag_lsu_rslt     = r_lsu_rslt;
endmodule

// File: tb/tb_pa_iu_ag_arb.sv
// tb_pa_iu_ag_arb: scoreboard bench for the AG arbiter with an ideal adder model
module tb_pa_iu_ag_arb;
  logic        cpuclk = 1'b0, cpurst = 1'b1, ifu_iu_flush = 1'b0;
  logic        bju_ag_req_vld = 1'b0, bju_ag_req_use_pc = 1'b0, bju_ag_req_rdy;
  logic [31:0] bju_ag_req_src0 = '0, bju_ag_req_imm = '0, bju_ag_req_pc = '0;
  logic        lsu_ag_req_vld = 1'b0, lsu_ag_req_rdy, lsu_ag_rslt_rdy = 1'b1;
  logic [31:0] lsu_ag_req_base = '0, lsu_ag_req_offset = '0;
  logic [31:0] ag_adder_rs1, ag_adder_rs2, ag_adder_res, ag_bju_rslt, ag_lsu_rslt;
  logic        ag_adder_bju_sel, ag_adder_lsu_wb, ag_bju_rslt_vld, ag_lsu_rslt_vld;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] bju_q[$], lsu_q[$];
  always #5 cpuclk = ~cpuclk;
  assign ag_adder_res = ag_adder_rs1 + ag_adder_rs2;
  pa_iu_ag_arb dut (
    .cpuclk(cpuclk), .cpurst(cpurst), .ifu_iu_flush(ifu_iu_flush),
    .bju_ag_req_vld(bju_ag_req_vld), .bju_ag_req_use_pc(bju_ag_req_use_pc),
    .bju_ag_req_src0(bju_ag_req_src0), .bju_ag_req_imm(bju_ag_req_imm),
    .bju_ag_req_pc(bju_ag_req_pc), .bju_ag_req_rdy(bju_ag_req_rdy),
    .lsu_ag_req_vld(lsu_ag_req_vld), .lsu_ag_req_base(lsu_ag_req_base),
    .lsu_ag_req_offset(lsu_ag_req_offset), .lsu_ag_req_rdy(lsu_ag_req_rdy),
    .ag_adder_rs1(ag_adder_rs1), .ag_adder_rs2(ag_adder_rs2),
    .ag_adder_bju_sel(ag_adder_bju_sel), .ag_adder_lsu_wb(ag_adder_lsu_wb),
    .ag_adder_res(ag_adder_res), .ag_bju_rslt_vld(ag_bju_rslt_vld),
    .ag_bju_rslt(ag_bju_rslt), .ag_lsu_rslt_vld(ag_lsu_rslt_vld),
    .ag_lsu_rslt(ag_lsu_rslt), .lsu_ag_rslt_rdy(lsu_ag_rslt_rdy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge cpuclk);
    #1;
  endtask
  task automatic bju(input logic v, input logic [31:0] s, input logic [31:0] i);
    bju_ag_req_vld = v; bju_ag_req_src0 = s; bju_ag_req_imm = i; bju_ag_req_use_pc = 1'b0;
  endtask
  task automatic lsu(input logic v, input logic [31:0] b, input logic [31:0] o);
    lsu_ag_req_vld = v; lsu_ag_req_base = b; lsu_ag_req_offset = o;
  endtask
  // results are popped as the DUT presents (BJU) or hands over (LSU) them
  always @(negedge cpuclk) begin
    if (ag_bju_rslt_vld) begin
      if (bju_q.size() == 0) chk("bju_unexpected_vld", 32'(ag_bju_rslt_vld), 0);
      else chk("bju_rslt", ag_bju_rslt, bju_q.pop_front());
    end
    if (ag_lsu_rslt_vld && lsu_ag_rslt_rdy) begin
      if (lsu_q.size() == 0) chk("lsu_unexpected_vld", 32'(ag_lsu_rslt_vld), 0);
      else chk("lsu_rslt", ag_lsu_rslt, lsu_q.pop_front());
    end
  end
  initial begin
    #2;
    chk("rst_bju_vld", 32'(ag_bju_rslt_vld), 0);
    chk("rst_lsu_vld", 32'(ag_lsu_rslt_vld), 0);
    chk("rst_lsu_rslt", ag_lsu_rslt, 0);
    chk("rst_bju_rslt", ag_bju_rslt, 0);
    tick(); tick();
    cpurst = 1'b0;
    tick();
    bju(1, 32'h1000, 32'h20);
    #1;
    chk("t1_bju_rdy", 32'(bju_ag_req_rdy), 1);
    chk("t1_lsu_rdy", 32'(lsu_ag_req_rdy), 0);
    chk("t1_rs1", ag_adder_rs1, 32'h1000);
    bju_q.push_back(32'h1020);
    tick();
    bju(0, 0, 0);
    #1;
    chk("t1_vld_now", 32'(ag_bju_rslt_vld), 1);
    tick();
    chk("t1_vld_pulse", 32'(ag_bju_rslt_vld), 0);
    bju(1, 32'h0, 32'h4);
    bju_ag_req_use_pc = 1'b1; bju_ag_req_pc = 32'h8000_0003;
    #1;
    chk("t2_rs1_pc", ag_adder_rs1, 32'h8000_0002);
    chk("t2_sel", 32'(ag_adder_bju_sel), 1);
    bju_q.push_back(32'h8000_0006);
    tick();
    bju(0, 0, 0);
    tick();
    for (int k = 0; k < 8; k++) begin
      bju(1, 32'h2000 + 32'(k) * 16, 32'h4);
      lsu(1, 32'h300 + 32'(k), 32'h1);
      #1;
      chk("t3_lsu_rdy", 32'(lsu_ag_req_rdy), 32'(k % 4 == 3));
      chk("t3_bju_rdy", 32'(bju_ag_req_rdy), 32'(k % 4 != 3));
      if (k % 4 == 3) lsu_q.push_back(32'h301 + 32'(k));
      else bju_q.push_back(32'h2004 + 32'(k) * 16);
      tick();
    end
    bju(0, 0, 0); lsu(0, 0, 0);
    tick();
    lsu_ag_rslt_rdy = 1'b0;
    lsu(1, 32'h100, 32'h8);
    #1;
    chk("t4_lsu_gnt", 32'(lsu_ag_req_rdy), 1);
    chk("t4_lsu_wb", 32'(ag_adder_lsu_wb), 1);
    lsu_q.push_back(32'h108);
    tick();
    for (int k = 0; k < 4; k++) begin
      lsu(1, 32'h200, 32'h8);
      #1;
      chk("t4_hold_rdy", 32'(lsu_ag_req_rdy), 0);
      chk("t4_hold_vld", 32'(ag_lsu_rslt_vld), 1);
      chk("t4_hold_rslt", ag_lsu_rslt, 32'h108);
      tick();
    end
    lsu_ag_rslt_rdy = 1'b1;
    bju(1, 32'h40, 32'h4);
    #1;
    chk("t4_cnt0_bju", 32'(bju_ag_req_rdy), 1);
    chk("t4_cnt0_lsu", 32'(lsu_ag_req_rdy), 0);
    bju_q.push_back(32'h44);
    tick();
    bju(0, 0, 0); lsu(1, 32'h200, 32'h10);
    #1;
    chk("t4_idle_gnt", 32'(lsu_ag_req_rdy), 1);
    lsu_q.push_back(32'h210);
    tick();
    lsu(1, 32'h300, 32'h4);
    #1;
    chk("t4_drain_gnt", 32'(lsu_ag_req_rdy), 1);
    lsu_q.push_back(32'h304);
    tick();
    lsu(0, 0, 0);
    tick();
    ifu_iu_flush = 1'b1;
    bju(1, 32'h10, 32'h10);
    #1;
    chk("t5_flush_bju_rdy", 32'(bju_ag_req_rdy), 0);
    chk("t5_flush_sel", 32'(ag_adder_bju_sel), 0);
    chk("t5_flush_rs1", ag_adder_rs1, 0);
    tick();
    ifu_iu_flush = 1'b0;
    #1;
    chk("t5_flush_novld", 32'(ag_bju_rslt_vld), 0);
    bju_q.push_back(32'h20);
    tick();
    bju(0, 0, 0); ifu_iu_flush = 1'b1;
    #1;
    chk("t5_vld_survives_flush", 32'(ag_bju_rslt_vld), 1);
    tick();
    bju(1, 32'h10, 32'h10); lsu(1, 32'h700, 32'h7);
    #1;
    chk("t5_flush_lsu_rdy", 32'(lsu_ag_req_rdy), 1);
    chk("t5_flush_bju_rdy2", 32'(bju_ag_req_rdy), 0);
    lsu_q.push_back(32'h707);
    tick();
    ifu_iu_flush = 1'b0; bju(0, 0, 0); lsu(0, 0, 0);
    tick();
    lsu_ag_rslt_rdy = 1'b0;
    lsu(1, 32'h500, 32'h5);
    tick();
    lsu(0, 0, 0);
    chk("t6_pre_vld", 32'(ag_lsu_rslt_vld), 1);
    chk("t6_pre_rslt", ag_lsu_rslt, 32'h505);
    cpurst = 1'b1;
    #1;
    chk("t6_rst_vld", 32'(ag_lsu_rslt_vld), 0);
    chk("t6_rst_rslt", ag_lsu_rslt, 0);
    tick();
    cpurst = 1'b0;
    lsu_ag_rslt_rdy = 1'b1;
    tick(); tick();
    chk("t6_post_vld", 32'(ag_lsu_rslt_vld), 0);
    tick();
    chk("bju_q_empty", 32'(bju_q.size()), 0);
    chk("lsu_q_empty", 32'(lsu_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
